// File: rtl/sar_code_assembler_if.sv
// Signal bundle between the SAR sequencer/comparator, the capacitive DAC and the digital back end.
interface sar_code_assembler_if #(
    parameter int unsigned N = 8
);
    logic         SAR_RESET;
    logic [N-2:0] OUTEN;
    logic         VCOMP;
    logic [N-1:0] DAC;
    logic [N-1:0] DOUT;
    logic         DOUT_VALID;
    logic         DOUT_READY;
    logic         OVERRUN;
    logic         SEQ_ERR;

    modport master (
        output SAR_RESET, OUTEN, VCOMP, DOUT_READY,
        input  DAC, DOUT, DOUT_VALID, OVERRUN, SEQ_ERR
    );

    modport slave (
        input  SAR_RESET, OUTEN, VCOMP, DOUT_READY,
        output DAC, DOUT, DOUT_VALID, OVERRUN, SEQ_ERR
    );
endinterface

// File: rtl/sar_code_assembler.sv
// SAR trial register and code assembler: follows the sequencer's bit strobes, builds the N-bit
// code and hands it to the back end through a one-deep valid/ready buffer.
module sar_code_assembler #(
    parameter int unsigned N = 8
) (
    input  logic                CLK,
    input  logic                RESET_N,
    sar_code_assembler_if.slave bus
);
    localparam int unsigned   KW    = $clog2(N);
    localparam logic [KW-1:0] K_MSB = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LAST
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [N-1:0]  dac_q, dac_d;
    logic [N-1:0]  dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          seq_err_q, seq_err_d;

    logic [KW-1:0] k_m1;
    logic [N-2:0]  exp_hot;
    logic          outen_nz;
    logic          multi_hot;
    logic [N-1:0]  final_code;
    logic          err;

    assign k_m1       = k_q - KW'(1);
    assign exp_hot    = (N-1)'(1) << k_m1;
    assign outen_nz   = |bus.OUTEN;
    assign multi_hot  = |(bus.OUTEN & (bus.OUTEN - (N-1)'(1)));
    assign final_code = {dac_q[N-1:1], bus.VCOMP};

    // Next-state, trial register and output buffer update.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        dac_d     = dac_q;
        dout_d    = dout_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        seq_err_d = 1'b0;
        err       = 1'b0;

        if (valid_q && bus.DOUT_READY) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        if (outen_nz && (bus.SAR_RESET || multi_hot)) begin
            err = 1'b1;
        end else if (bus.SAR_RESET) begin
            // Sample phase restarts from mid-scale, silently dropping any conversion in flight.
            dac_d   = {1'b1, {(N-1){1'b0}}};
            k_d     = K_MSB;
            state_d = CONV;
        end else begin
            case (state_q)
                IDLE: err = outen_nz;
                CONV: begin
                    if (outen_nz) begin
                        if (bus.OUTEN == exp_hot) begin
                            dac_d[k_q]  = bus.VCOMP;
                            dac_d[k_m1] = 1'b1;
                            if (k_q == KW'(1)) begin
                                state_d = LAST;
                            end else begin
                                k_d = k_m1;
                            end
                        end else begin
                            err = 1'b1;
                        end
                    end
                end
                LAST: begin
                    if (outen_nz) begin
                        err = 1'b1;
                    end else begin
                        // A new code wins over an unconsumed one; flag it unless it leaves this cycle.
                        dout_d  = final_code;
                        dac_d   = final_code;
                        valid_d = 1'b1;
                        if (valid_q && !bus.DOUT_READY) begin
                            overrun_d = 1'b1;
                        end
                        k_d     = K_MSB;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (err) begin
            seq_err_d = 1'b1;
            dac_d     = '0;
            k_d       = K_MSB;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            k_q       <= K_MSB;
            dac_q     <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            dac_q     <= dac_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign bus.DAC        = dac_q;
    assign bus.DOUT       = dout_q;
    assign bus.DOUT_VALID = valid_q;
    assign bus.OVERRUN    = overrun_q;
    assign bus.SEQ_ERR    = seq_err_q;
endmodule

// File: tb/tb_sar_code_assembler.sv
// Randomized scoreboard bench for sar_code_assembler: each conversion's Vin is the expected code,
// and a monitor checks every buffered code, OVERRUN and DOUT_VALID at the consumer side.
module tb_sar_code_assembler;
    localparam int unsigned N = 8;
    localparam logic [7:0] NOM_DAC [9] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hB8,
                                           8'hB4, 8'hB2, 8'hB3, 8'hB2};

    typedef struct {
        logic [7:0] code;
        bit         ovr;
        bit         dropped;
    } ent_t;

    logic CLK = 1'b0;
    logic RESET_N;

    sar_code_assembler_if #(.N(N)) bus ();
    sar_code_assembler #(.N(N)) dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         fails  = 0;
    ent_t       issued[$];
    int         rd_idx = 0;
    bit         mon_en = 1'b0;
    logic [7:0] model_dac = 8'h00;
    logic [7:0] dac_log[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%02h, required 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Ideal SAR trial after deciding bit i of vin: decided bits kept, bit i-1 set, rest clear.
    function automatic logic [7:0] trial(input logic [7:0] vin, input int i);
        return (vin & ~((8'(1) << i) - 8'(1))) | (8'(1) << (i - 1));
    endfunction

    function automatic logic pick_rdy(input int mode, input bit last);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($urandom);
            default: return last;
        endcase
    endfunction

    task automatic step(input logic sr, input logic [6:0] oe, input logic vc, input logic rdy,
                        input logic [7:0] exp_dac, input logic exp_err);
        bus.SAR_RESET  = sr;
        bus.OUTEN      = oe;
        bus.VCOMP      = vc;
        bus.DOUT_READY = rdy;
        @(posedge CLK);
        #1;
        chk("dac", bus.DAC, exp_dac);
        chk("seq_err", 8'(bus.SEQ_ERR), 8'(exp_err));
        dac_log.push_back(bus.DAC);
        model_dac = exp_dac;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int c = 0; c < n; c++) step(1'b0, 7'h00, 1'($urandom), rdy, model_dac, 1'b0);
    endtask

    // Full conversion of vin; the comparator answers with the true bit of vin at each decision.
    task automatic convert(input logic [7:0] vin, input int mode);
        logic r;
        step(1'b1, 7'h00, 1'($urandom), pick_rdy(mode, 1'b0), 8'h80, 1'b0);
        for (int i = 7; i >= 1; i--)
            step(1'b0, 7'(1) << (i - 1), vin[i], pick_rdy(mode, 1'b0), trial(vin, i), 1'b0);
        r = pick_rdy(mode, 1'b1);
        step(1'b0, 7'h00, vin[0], r, vin, 1'b0);
        if (!r && issued.size() > rd_idx) begin
            issued[issued.size() - 1].dropped = 1'b1;
            issued.push_back('{code: vin, ovr: 1'b1, dropped: 1'b0});
        end else begin
            issued.push_back('{code: vin, ovr: 1'b0, dropped: 1'b0});
        end
    endtask

    task automatic expect_err(input logic sr, input logic [6:0] oe);
        step(sr, oe, 1'($urandom), 1'b1, 8'h00, 1'b1);
        step(1'b0, 7'h00, 1'($urandom), 1'b1, 8'h00, 1'b0);
    endtask

    // Consumer-side monitor: compares the buffered code and flags on every cycle.
    initial begin
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                while (rd_idx < issued.size() && issued[rd_idx].dropped) rd_idx++;
                if (rd_idx < issued.size()) begin
                    chk("mon_valid", 8'(bus.DOUT_VALID), 8'h01);
                    chk("mon_dout", bus.DOUT, issued[rd_idx].code);
                    chk("mon_overrun", 8'(bus.OVERRUN), 8'(issued[rd_idx].ovr));
                    if (bus.DOUT_READY) rd_idx++;
                end else begin
                    chk("mon_valid", 8'(bus.DOUT_VALID), 8'h00);
                    chk("mon_overrun", 8'(bus.OVERRUN), 8'h00);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        RESET_N        = 1'b1;
        bus.SAR_RESET  = 1'b0;
        bus.OUTEN      = 7'h00;
        bus.VCOMP      = 1'b0;
        bus.DOUT_READY = 1'b0;
        #1 RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_dac", bus.DAC, 8'h00);
        chk("rst_dout", bus.DOUT, 8'h00);
        chk("rst_valid", 8'(bus.DOUT_VALID), 8'h00);
        chk("rst_overrun", 8'(bus.OVERRUN), 8'h00);
        chk("rst_seq_err", 8'(bus.SEQ_ERR), 8'h00);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        mon_en = 1'b1;

        // Nominal conversion with the reference DAC trajectory.
        dac_log.delete();
        convert(8'hB2, 1);
        for (int i = 0; i < 9; i++) chk("nominal_dac_seq", dac_log[i], NOM_DAC[i]);
        chk("nominal_dout", bus.DOUT, 8'hB2);
        chk("nominal_valid", 8'(bus.DOUT_VALID), 8'h01);
        idle(1, 1'b1);
        chk("nominal_valid_1cyc", 8'(bus.DOUT_VALID), 8'h00);

        // Extremes.
        convert(8'hFF, 1);
        chk("all_ones", bus.DOUT, 8'hFF);
        dac_log.delete();
        convert(8'h00, 1);
        chk("all_zeros", bus.DOUT, 8'h00);
        chk("all_zeros_dac_msb", dac_log[1], 8'h40);
        chk("all_zeros_dac_lsb", dac_log[7], 8'h01);
        idle(2, 1'b1);

        // Backpressure across two conversions.
        convert(8'h5A, 0);
        convert(8'h3C, 0);
        chk("bp_dout", bus.DOUT, 8'h3C);
        chk("bp_overrun", 8'(bus.OVERRUN), 8'h01);
        idle(1, 1'b1);
        chk("bp_valid_after", 8'(bus.DOUT_VALID), 8'h00);
        chk("bp_overrun_after", 8'(bus.OVERRUN), 8'h00);
        idle(1, 1'b0);

        // Accept and complete in the same cycle.
        convert(8'h11, 0);
        idle(1, 1'b0);
        convert(8'h22, 3);
        chk("simul_dout", bus.DOUT, 8'h22);
        chk("simul_valid", 8'(bus.DOUT_VALID), 8'h01);
        chk("simul_overrun", 8'(bus.OVERRUN), 8'h00);
        idle(2, 1'b1);

        // Protocol violations.
        step(1'b1, 7'h00, 1'b0, 1'b1, 8'h80, 1'b0);
        expect_err(1'b0, 7'h20);
        step(1'b1, 7'h00, 1'b0, 1'b1, 8'h80, 1'b0);
        expect_err(1'b0, 7'h60);
        expect_err(1'b0, 7'h08);
        expect_err(1'b1, 7'h40);
        v = 8'($urandom);
        step(1'b1, 7'h00, 1'b0, 1'b1, 8'h80, 1'b0);
        for (int i = 7; i >= 1; i--)
            step(1'b0, 7'(1) << (i - 1), v[i], 1'b1, trial(v, i), 1'b0);
        expect_err(1'b0, 7'h01);

        // Abort mid-conversion by a new sample phase.
        v = 8'h9C;
        step(1'b1, 7'h00, 1'b0, 1'b1, 8'h80, 1'b0);
        for (int i = 7; i >= 5; i--)
            step(1'b0, 7'(1) << (i - 1), v[i], 1'b1, trial(v, i), 1'b0);
        convert(8'h47, 1);
        idle(2, 1'b1);

        // Asynchronous reset mid-conversion with a code still buffered.
        convert(8'hA5, 0);
        step(1'b1, 7'h00, 1'b0, 1'b0, 8'h80, 1'b0);
        step(1'b0, 7'h40, 1'b1, 1'b0, 8'hC0, 1'b0);
        mon_en = 1'b0;
        #2 RESET_N = 1'b0;
        #1;
        chk("async_dac", bus.DAC, 8'h00);
        chk("async_dout", bus.DOUT, 8'h00);
        chk("async_valid", 8'(bus.DOUT_VALID), 8'h00);
        chk("async_overrun", 8'(bus.OVERRUN), 8'h00);
        chk("async_seq_err", 8'(bus.SEQ_ERR), 8'h00);
        for (int i = 0; i < issued.size(); i++) issued[i].dropped = 1'b1;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        model_dac = 8'h00;
        mon_en    = 1'b1;

        // Randomized conversions with mixed consumer behaviour.
        for (int t = 0; t < 40; t++) begin
            convert(8'($urandom), int'($urandom_range(0, 3)));
            idle(int'($urandom_range(0, 2)), 1'($urandom));
        end

        for (int n = 0; n < 10 && issued.size() > rd_idx; n++) idle(1, 1'b1);
        chk("drain_empty", 8'(issued.size() > rd_idx), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/sar_code_assembler.md
Name: sar_code_assembler

Overview:
- Datapath end of the SAR ADC control protocol, sitting beside the top-level sequencing FSM.
- Consumes the sequencer's one-hot bit-enable strobes, SAR reset pulse and comparator output.
- Runs the successive-approximation trial register that drives the capacitive DAC.
- Assembles the final N-bit code and hands it to the digital back end over a one-deep valid/ready buffer, with overrun and sequence-error flags.

Parameters:
- N, 8, conversion resolution in bits; OUTEN width is N-1.

Ports:
- CLK  input  1  clock.
- RESET_N  input  1  asynchronous active-low reset.
- SAR_RESET  input  1  sample-phase strobe from sequencer; starts a conversion.
- OUTEN  input  N-1  one-hot bit strobe; OUTEN[N-2] = MSB decision cycle, OUTEN[0] = bit-1 decision cycle.
- VCOMP  input  1  comparator; 1 = Vin above current DAC trial, so keep the bit.
- DAC  output  N  trial code driving the capacitor array.
- DOUT  output  N  completed conversion code.
- DOUT_VALID  output  1  DOUT holds an unconsumed code.
- DOUT_READY  input  1  consumer accepts DOUT when high with DOUT_VALID.
- OVERRUN  output  1  sticky; a completed code overwrote an unconsumed one.
- SEQ_ERR  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (async, RESET_N=0): DAC=0, DOUT=0, DOUT_VALID=0, OVERRUN=0, SEQ_ERR=0, state IDLE, expected index k=N-1.
- States: IDLE, CONV (k = bit under decision, N-1..1), LAST (bit 0 decision).
- Start:
  - SAR_RESET=1 in any state with OUTEN=0: DAC <= 1<<(N-1), k <= N-1, go to CONV.
  - This aborts any conversion in progress without error and without a result.
- CONV with OUTEN == 1<<(k-1) (exactly one hot, expected position):
  - DAC[k] <= VCOMP.
  - DAC[k-1] <= 1.
  - If k==1 go to LAST, else k <= k-1.
- LAST (the cycle after the OUTEN[0] cycle) requires OUTEN=0 and SAR_RESET=0:
  - Final code = {DAC[N-1:1], VCOMP}.
  - Load it into DOUT; DAC <= final code; go to IDLE.
  - DOUT_VALID is high from the next cycle, i.e. one cycle after LAST.
  - Conversion latency: SAMPLE cycle + N decision cycles; result visible on cycle N+1 after SAR_RESET.
- Protocol violations: any of the following pulses SEQ_ERR for one cycle, sets DAC <= 0, goes to IDLE and produces no result:
  - OUTEN multi-hot.
  - OUTEN at a position other than expected in CONV.
  - OUTEN nonzero in IDLE or LAST.
  - SAR_RESET asserted together with nonzero OUTEN.
- IDLE with OUTEN=0 and SAR_RESET=0: hold DAC, no action.
- Output buffer:
  - Transfer occurs when DOUT_VALID & DOUT_READY; DOUT_VALID then clears unless a new code loads in the same cycle.
  - New code loading while DOUT_VALID=1 and DOUT_READY=0: DOUT is overwritten, DOUT_VALID stays 1, OVERRUN <= 1.
  - New code loading in the same cycle as a transfer: no overrun; DOUT takes the new code and DOUT_VALID stays 1.
  - OVERRUN clears on the next completed transfer.
  - DOUT is stable while DOUT_VALID=1 and DOUT_READY=0, except on overwrite.
- VCOMP is sampled only on decision cycles; it is ignored otherwise.
- All outputs are registered.

Test Plan:
- Nominal code: reset, then SAR_RESET then OUTEN 0x40..0x01 then 0x00, with VCOMP 1,0,1,1,0,0,1,0 and DOUT_READY=1.
  - Required DAC sequence: 0x80, 0xC0, 0xA0, 0xB0, 0xB8, 0xB4, 0xB2, 0xB3, 0xB2.
  - Required result: DOUT=0xB2 with DOUT_VALID for 1 cycle.
- Extremes: VCOMP held at 1 gives DOUT=0xFF; VCOMP held at 0 gives DOUT=0x00. DAC never leaves 0x80 pattern-halving, e.g. 0x80, 0x40 … 0x01, 0x00 for the all-zeros case.
- Backpressure: DOUT_READY=0 across two conversions (0x5A then 0x3C).
  - Required: DOUT=0x3C, OVERRUN=1.
  - Then DOUT_READY=1 for 1 cycle gives transfer, DOUT_VALID=0, OVERRUN=0.
- Simultaneous accept and complete: DOUT_VALID=1 holding 0x11, DOUT_READY=1 in the cycle 0x22 completes.
  - Required: DOUT=0x22, DOUT_VALID=1, OVERRUN=0.
- Protocol errors, each giving a SEQ_ERR 1-cycle pulse, DAC=0, no DOUT_VALID:
  - OUTEN=0x20 when 0x40 is expected.
  - OUTEN=0x60 (multi-hot).
  - OUTEN=0x08 while IDLE.
- Abort and reset:
  - SAR_RESET mid-conversion (after 0x10): restarts, DAC=0x80, no SEQ_ERR, only the second code appears.
  - RESET_N low mid-conversion: all outputs 0 immediately (asynchronously).
